// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer
//   Runs one nibble-CPU session from a host nibble stream: CPU reset pulse,
//   LOADPROG / LOADDATA / SETRUNPT bursts taken back to back from the host,
//   then a RUNPROG window whose CPU output is sampled every cycle.
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   start, abort     session control (start only honoured in IDLE)
//   run_cycles       RUN length, latched at start; 0 = run until abort
//   in_valid/in_data host nibble stream; in_ready = nibble consumed
//   cpu_out          CPU io_out, sampled during RUN
//   cpu_data/cpu_instr/cpu_reset  registered drive of the CPU interface
//   out_valid/out_data            registered run-cycle samples
//   busy, done, err, phase        status (phase = state code)
module cpu_boot_sequencer #(
   parameter int PROG_LEN  = 16,
   parameter int DATA_LEN  = 16,
   parameter int RUNPT_LEN = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] run_cycles,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   input  logic [7:0] cpu_out,
   output logic [3:0] cpu_data,
   output logic [1:0] cpu_instr,
   output logic       cpu_reset,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CRST  = 3'd1,
      S_PROG  = 3'd2,
      S_DATA  = 3'd3,
      S_RUNPT = 3'd4,
      S_RUN   = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   localparam logic [1:0] I_RUNPROG = 2'd3;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;          // nibbles taken in current load phase
   logic [7:0] run_cnt_q, run_cnt_d;  // RUN cycles elapsed (saturating)
   logic [7:0] run_lim_q, run_lim_d;  // run_cycles latched at start
   logic       cpu_reset_q, cpu_reset_d;
   logic [1:0] cpu_instr_q, cpu_instr_d;
   logic [3:0] cpu_data_q, cpu_data_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_data_q, out_data_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   // per-load-phase parameters
   logic [7:0] load_len;
   logic [1:0] load_instr;
   state_t     load_next;
   logic       is_load;

   always_comb begin
      load_len   = 8'(PROG_LEN);
      load_instr = 2'd0;
      load_next  = S_DATA;
      is_load    = 1'b0;
      case (state_q)
         S_PROG:  begin load_len = 8'(PROG_LEN);  load_instr = 2'd0; load_next = S_DATA;  is_load = 1'b1; end
         S_DATA:  begin load_len = 8'(DATA_LEN);  load_instr = 2'd1; load_next = S_RUNPT; is_load = 1'b1; end
         S_RUNPT: begin load_len = 8'(RUNPT_LEN); load_instr = 2'd2; load_next = S_RUN;   is_load = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_cnt_d   = run_cnt_q;
      run_lim_d   = run_lim_q;
      cpu_reset_d = 1'b0;
      cpu_instr_d = I_RUNPROG;
      cpu_data_d  = 4'd0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      err_d       = err_q;
      in_ready    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d   = S_CRST;
               run_lim_d = run_cycles;
               err_d     = 1'b0;
            end
         end
         S_CRST: begin
            cpu_reset_d = 1'b1;
            cnt_d       = 8'd0;
            run_cnt_d   = 8'd0;
            state_d     = S_PROG;
         end
         S_PROG, S_DATA, S_RUNPT: begin
            if (in_valid) begin
               in_ready    = 1'b1;
               cpu_instr_d = load_instr;
               cpu_data_d  = in_data;
               if ({1'b0, cnt_q} + 9'd1 == {1'b0, load_len}) begin
                  cnt_d   = 8'd0;
                  state_d = load_next;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               // underrun: park the CPU in reset and flag it
               state_d     = S_ERR;
               err_d       = 1'b1;
               cpu_reset_d = 1'b1;
            end
         end
         S_RUN: begin
            out_valid_d = 1'b1;
            out_data_d  = cpu_out;
            if (run_cnt_q != 8'hFF) run_cnt_d = run_cnt_q + 8'd1;
            if (run_lim_q != 8'd0 && ({1'b0, run_cnt_q} + 9'd1 == {1'b0, run_lim_q})) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_ERR: begin
            cpu_reset_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // abort overrides everything decided above (outside IDLE)
      if (abort && state_q != S_IDLE) begin
         state_d     = S_IDLE;
         cpu_reset_d = 1'b1;
         cpu_instr_d = I_RUNPROG;
         cpu_data_d  = 4'd0;
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
         done_d      = 1'b0;
         err_d       = err_q;
         in_ready    = 1'b0;
         cnt_d       = cnt_q;
         run_cnt_d   = run_cnt_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         run_cnt_q   <= 8'd0;
         run_lim_q   <= 8'd0;
         cpu_reset_q <= 1'b1;
         cpu_instr_q <= I_RUNPROG;
         cpu_data_q  <= 4'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_cnt_q   <= run_cnt_d;
         run_lim_q   <= run_lim_d;
         cpu_reset_q <= cpu_reset_d;
         cpu_instr_q <= cpu_instr_d;
         cpu_data_q  <= cpu_data_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign cpu_reset = cpu_reset_q;
   assign cpu_instr = cpu_instr_q;
   assign cpu_data  = cpu_data_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);
   assign phase     = state_q;

endmodule
